// File: rtl/palette_pkg.sv
// Shared types and constants for the palette lookup: default palette contents,
// palette entry layout and the default blink half-period.
package palette_pkg;

  localparam int BLINK_FRAMES_DEFAULT = 30;
  localparam int DEF_RGB_W            = 24;
  localparam int DEF_ENTRIES          = 16;

  typedef struct packed {
    logic [DEF_RGB_W-1:0] colour;
    logic                 blink;
  } pal_entry_t;

  localparam logic [DEF_RGB_W-1:0] DEFAULT_PALETTE [DEF_ENTRIES] = '{
    24'hFFFFFF, 24'h4CFFFC, 24'h52BAC3, 24'h66989F,
    24'hAAA4AE, 24'h292E31, 24'h3A4342, 24'h000909,
    24'h8FDE5D, 24'h702A00, 24'hD56E45, 24'hBF6540,
    24'hFF6B97, 24'hFB8347, 24'h2F2A4B, 24'hE01F1F
  };

  // Entries beyond the built-in palette come up black with blink cleared.
  function automatic pal_entry_t default_entry(input int idx);
    pal_entry_t e;
    e.blink  = 1'b0;
    e.colour = '0;
    if (idx < DEF_ENTRIES) e.colour = DEFAULT_PALETTE[idx[3:0]];
    return e;
  endfunction

endpackage

// File: rtl/palette_blink_timer.sv
// Frame counter that toggles the blink phase every BLINK_FRAMES frame strobes.
module palette_blink_timer
  import palette_pkg::*;
#(
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start_i,
  output logic blink_phase_o
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_start_i) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_phase_o = phase_q;

endmodule

// File: rtl/palette_lut.sv
// Double-buffered colour palette with a 2-stage pixel lookup pipeline;
// shadow writes are committed to the active bank on a frame strobe.
module palette_lut
  import palette_pkg::*;
#(
  parameter int IDX_W        = 4,
  parameter int RGB_W        = 24,
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid_i,
  input  logic             pix_active_i,
  input  logic [IDX_W-1:0] pix_idx_i,
  input  logic             frame_start_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [RGB_W-1:0] wr_data_i,
  input  logic             wr_blink_i,
  output logic [RGB_W-1:0] rgb_o,
  output logic             rgb_valid_o,
  output logic             pending_o
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [RGB_W-1:0] active_col [DEPTH];
  logic             active_blk [DEPTH];
  logic             pending_q, pending_d;
  logic             commit;
  logic             blink_phase;

  assign commit = frame_start_i & pending_q;

  // A write in the commit cycle lands in shadow only, so pending must survive.
  always_comb begin
    pending_d = pending_q;
    if (wr_en_i)            pending_d = 1'b1;
    else if (frame_start_i) pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= 1'b0;
    else     pending_q <= pending_d;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam pal_entry_t       RST_ENTRY = default_entry(gi);
      localparam logic [RGB_W-1:0] RST_COL   = RGB_W'(RST_ENTRY.colour);

      logic [RGB_W-1:0] sh_col_q, ac_col_q;
      logic             sh_blk_q, ac_blk_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sh_col_q <= RST_COL;
          sh_blk_q <= RST_ENTRY.blink;
        end else if (wr_en_i && (wr_addr_i == IDX_W'(gi))) begin
          sh_col_q <= wr_data_i;
          sh_blk_q <= wr_blink_i;
        end
      end

      // Commit copies the pre-write shadow value sampled at this edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ac_col_q <= RST_COL;
          ac_blk_q <= RST_ENTRY.blink;
        end else if (commit) begin
          ac_col_q <= sh_col_q;
          ac_blk_q <= sh_blk_q;
        end
      end

      assign active_col[gi] = ac_col_q;
      assign active_blk[gi] = ac_blk_q;
    end
  endgenerate

  palette_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .clk          (clk),
    .rst          (rst),
    .frame_start_i(frame_start_i),
    .blink_phase_o(blink_phase)
  );

  logic             s1_valid_q, s1_active_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             rgb_valid_q;

  // Lookup happens at the stage-2 edge, so it sees active as of that edge.
  always_comb begin
    rgb_d = '0;
    if (s1_valid_q && s1_active_q) begin
      if (active_blk[s1_idx_q] && blink_phase) rgb_d = active_col[0];
      else                                     rgb_d = active_col[s1_idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_active_q <= 1'b0;
      s1_idx_q    <= '0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= pix_valid_i;
      s1_active_q <= pix_active_i;
      s1_idx_q    <= pix_idx_i;
      rgb_q       <= rgb_d;
      rgb_valid_q <= s1_valid_q;
    end
  end

  assign rgb_o       = rgb_q;
  assign rgb_valid_o = rgb_valid_q;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_palette_lut.sv
// Randomised scoreboard bench for palette_lut against a frame-level palette model.
module tb_palette_lut;

  localparam int IDX_W = 4;
  localparam int RGB_W = 24;
  localparam int BF    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             pix_valid_i, pix_active_i, frame_start_i;
  logic [IDX_W-1:0] pix_idx_i, wr_addr_i;
  logic             wr_en_i, wr_blink_i;
  logic [RGB_W-1:0] wr_data_i, rgb_o;
  logic             rgb_valid_o, pending_o;

  always #5 clk = ~clk;

  palette_lut #(
    .IDX_W(IDX_W),
    .RGB_W(RGB_W),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid_i  (pix_valid_i),
    .pix_active_i (pix_active_i),
    .pix_idx_i    (pix_idx_i),
    .frame_start_i(frame_start_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .wr_blink_i   (wr_blink_i),
    .rgb_o        (rgb_o),
    .rgb_valid_o  (rgb_valid_o),
    .pending_o    (pending_o)
  );

  typedef struct {
    logic [23:0] rgb;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  bit   mon_en = 1'b0;

  localparam logic [23:0] REF_PAL [16] = '{
    24'hFFFFFF, 24'h4CFFFC, 24'h52BAC3, 24'h66989F,
    24'hAAA4AE, 24'h292E31, 24'h3A4342, 24'h000909,
    24'h8FDE5D, 24'h702A00, 24'hD56E45, 24'hBF6540,
    24'hFF6B97, 24'hFB8347, 24'h2F2A4B, 24'hE01F1F
  };

  // Model: two banks, a pending flag and a running frame count since reset.
  logic [23:0] m_sh_col [16];
  logic [23:0] m_ac_col [16];
  bit          m_sh_blk [16];
  bit          m_ac_blk [16];
  bit          m_pending;
  int          m_frames;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_sh_col[i] = REF_PAL[i];
      m_ac_col[i] = REF_PAL[i];
      m_sh_blk[i] = 1'b0;
      m_ac_blk[i] = 1'b0;
    end
    m_pending = 1'b0;
    m_frames  = 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
  endtask

  // One clock of stimulus; the model is advanced with what the DUT sampled.
  task automatic cycle(input bit pv, input bit pa, input logic [3:0] idx, input bit fs,
                       input bit we, input logic [3:0] wa, input logic [23:0] wd, input bit wb);
    exp_t e;
    bit   phase;
    pix_valid_i   = pv;
    pix_active_i  = pa;
    pix_idx_i     = idx;
    frame_start_i = fs;
    wr_en_i       = we;
    wr_addr_i     = wa;
    wr_data_i     = wd;
    wr_blink_i    = wb;
    @(posedge clk);
    #1;
    if (fs && m_pending) begin
      for (int i = 0; i < 16; i++) begin
        m_ac_col[i] = m_sh_col[i];
        m_ac_blk[i] = m_sh_blk[i];
      end
    end
    if (fs) m_frames++;
    if (we) begin
      m_sh_col[wa] = wd;
      m_sh_blk[wa] = wb;
      m_pending    = 1'b1;
    end else if (fs) begin
      m_pending = 1'b0;
    end
    phase   = ((m_frames / BF) % 2) == 1;
    e.valid = pv;
    e.rgb   = 24'h0;
    if (pv && pa) e.rgb = (m_ac_blk[idx] && phase) ? m_ac_col[0] : m_ac_col[idx];
    exp_q.push_back(e);
    check("pending", {31'b0, pending_o}, {31'b0, m_pending});
  endtask

  task automatic pix(input logic [3:0] idx, input bit pa);
    cycle(1'b1, pa, idx, 1'b0, 1'b0, 4'd0, 24'h0, 1'b0);
  endtask

  task automatic frame();
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 24'h0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 24'h0, 1'b0);
  endtask

  task automatic set_idle_inputs();
    pix_valid_i = 0; pix_active_i = 0; pix_idx_i = '0; frame_start_i = 0;
    wr_en_i = 0; wr_addr_i = '0; wr_data_i = '0; wr_blink_i = 0;
  endtask

  // Reset arrives while a write to entry 9 is being presented; it must be lost.
  task automatic do_reset();
    mon_en = 1'b0;
    exp_q.delete();
    wr_en_i   = 1'b1;
    wr_addr_i = 4'd9;
    wr_data_i = 24'h999999;
    #2;
    rst = 1'b1;
    #1;
    check("rst_rgb", {8'b0, rgb_o}, 32'h0);
    check("rst_valid", {31'b0, rgb_valid_o}, 32'h0);
    check("rst_pending", {31'b0, pending_o}, 32'h0);
    set_idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        check("pix", {7'b0, rgb_valid_o, rgb_o}, {7'b0, e.valid, e.rgb});
        if (e.valid)
          $display("t=%0t pixel rgb=%06h valid=%0b (expected %06h)", $time, rgb_o, rgb_valid_o, e.rgb);
      end
    end
  end

  initial begin : driver
    rst = 1'b1;
    set_idle_inputs();
    #3;
    check("init_rgb", {8'b0, rgb_o}, 32'h0);
    check("init_valid", {31'b0, rgb_valid_o}, 32'h0);
    check("init_pending", {31'b0, pending_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Default palette sweep, including index 3.
    for (int i = 0; i < 16; i++) pix(4'(i), 1'b1);

    // Shadow write to 5 stays invisible until a frame strobe commits it.
    cycle(1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 4'd5, 24'h123456, 1'b0);
    repeat (3) pix(4'd5, 1'b1);
    frame();
    repeat (3) pix(4'd5, 1'b1);

    // Write to 2 coinciding with the strobe lands in shadow only.
    cycle(1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd2, 24'hABCDEF, 1'b0);
    repeat (3) pix(4'd2, 1'b1);
    frame();
    repeat (3) pix(4'd2, 1'b1);

    // Blanking and invalid pixels.
    repeat (2) pix(4'd1, 1'b0);
    cycle(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 24'h0, 1'b0);

    // Blinking entry 4 across several blink half-periods.
    cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 24'hAAA4AE, 1'b1);
    frame();
    for (int f = 0; f < 8; f++) begin
      repeat (2) pix(4'd4, 1'b1);
      frame();
    end

    // Pixels in flight across a commit edge.
    cycle(1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 4'd6, 24'h0F0F0F, 1'b0);
    pix(4'd6, 1'b1);
    cycle(1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 4'd0, 24'h0, 1'b0);
    repeat (2) pix(4'd6, 1'b1);

    // Pending write to 7 then reset: everything returns to defaults.
    cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 24'h777777, 1'b0);
    idle();
    do_reset();
    for (int i = 0; i < 16; i++) pix(4'(i), 1'b1);
    frame();
    pix(4'd7, 1'b1);
    pix(4'd9, 1'b1);

    for (int n = 0; n < 500; n++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
            24'($urandom), ($urandom_range(0, 2) == 0));
    end

    repeat (4) idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
